alu_mult_seq: RTL and testbench



---
 rtl/alu_mult_pkg.sv | 22 ++
 rtl/alu_mult_if.sv | 37 +++
 rtl/alu_mult_step.sv | 29 ++
 rtl/alu_mult_seq.sv | 141 ++++++++++++++
 tb/tb_alu_mult_seq.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_mult_pkg.sv
// alu_mult_pkg
// Shared definitions for the sequential sign-magnitude multiplier:
//   - state_t       : FSM state encoding (IDLE / RUN / DONE)
//   - DEFAULT_WIDTH : default operand magnitude width
//   - count_width() : width of the iteration counter, able to hold WIDTH
// No ports (package).
package alu_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // The counter is loaded with WIDTH itself, so it needs room for WIDTH+1 values.
   function automatic int count_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/alu_mult_if.sv
// alu_mult_if
// Handshake bundle for the sequential multiplier.
//   Input side : in_valid, in_ready, a, b, sign_a, sign_b
//   Output side: out_valid, out_ready, product, final_sign
//   Status     : busy
// Modports:
//   master - the ALU sequencer (drives operands, takes results)
//   slave  - the multiplier
interface alu_mult_if
   import alu_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               sign_a;
   logic               sign_b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] product;
   logic               final_sign;
   logic               busy;

   modport master (
      output in_valid, a, b, sign_a, sign_b, out_ready,
      input  in_ready, out_valid, product, final_sign, busy
   );

   modport slave (
      input  in_valid, a, b, sign_a, sign_b, out_ready,
      output in_ready, out_valid, product, final_sign, busy
   );

endinterface

// File: rtl/alu_mult_step.sv
// alu_mult_step
// One combinational shift-and-add iteration of the multiplier.
//   acc, mcand, mplier        : current datapath registers
//   acc_next                  : acc + mcand when mplier[0] is set, else acc
//   mcand_next, mplier_next   : multiplicand shifted left, multiplier shifted right
//   mplier_zero               : no set bits remain in mplier_next
module alu_mult_step
   import alu_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [2*WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic [2*WIDTH-1:0] acc_next,
   output logic [2*WIDTH-1:0] mcand_next,
   output logic [WIDTH-1:0]   mplier_next,
   output logic               mplier_zero
);

   // The accumulator is 2*WIDTH bits wide, so the partial sum can never wrap.
   always_comb begin
      acc_next    = mplier[0] ? (acc + mcand) : acc;
      mcand_next  = mcand << 1;
      mplier_next = mplier >> 1;
      mplier_zero = (mplier_next == '0);
   end

endmodule

// File: rtl/alu_mult_seq.sv
// alu_mult_seq
// Sequential sign-magnitude multiplier with valid/ready handshakes.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_mult_if.slave (operands, result, handshakes, busy)
// Build option:
//   ALU_MULT_EARLY_DONE_EN - leave RUN as soon as the remaining multiplier
//   bits are all zero (b == 0 goes straight to DONE on acceptance).
module alu_mult_seq
   import alu_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_mult_if.slave  bus
);

   localparam int CW = count_width(WIDTH);

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      count_q, count_d;
   logic               sign_q, sign_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;

   logic [2*WIDTH-1:0] step_acc;
   logic [2*WIDTH-1:0] step_mcand;
   logic [WIDTH-1:0]   step_mplier;
   logic               step_zero;

   alu_mult_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .acc         (acc_q),
      .mcand       (mcand_q),
      .mplier      (mplier_q),
      .acc_next    (step_acc),
      .mcand_next  (step_mcand),
      .mplier_next (step_mplier),
      .mplier_zero (step_zero)
   );

`ifndef ALU_MULT_EARLY_DONE_EN
   // Fixed-latency build runs every iteration, so the zero flag has no consumer.
   logic unused_step_zero;
   assign unused_step_zero = step_zero;
`endif

   // Next-state and datapath logic. Handshake outputs are decoded from the
   // next state so they come straight out of flops and never depend
   // combinationally on in_valid or out_ready.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      sign_d   = sign_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               acc_d    = '0;
               mcand_d  = {{WIDTH{1'b0}}, bus.a};
               mplier_d = bus.b;
               count_d  = CW'(WIDTH);
               sign_d   = bus.sign_a ^ bus.sign_b;
`ifdef ALU_MULT_EARLY_DONE_EN
               state_d  = (bus.b == '0) ? DONE : RUN;
`else
               state_d  = RUN;
`endif
            end
         end
         RUN: begin
            acc_d    = step_acc;
            mcand_d  = step_mcand;
            mplier_d = step_mplier;
            count_d  = count_q - CW'(1);
            if (count_d == '0) begin
               state_d = DONE;
            end
`ifdef ALU_MULT_EARLY_DONE_EN
            if (step_zero) begin
               state_d = DONE;
            end
`endif
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // State and datapath registers; reset cancels any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         count_q     <= '0;
         sign_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         count_q     <= count_d;
         sign_q      <= sign_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   // A zero magnitude always reports a positive sign.
   assign bus.product    = acc_q;
   assign bus.final_sign = sign_q & (|acc_q);
   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// tb_alu_mult_seq
// Self-checking bench for alu_mult_seq (WIDTH = 8): a vector table driven
// through a scoreboard queue, plus backpressure and mid-run reset sequences.
// Honours ALU_MULT_EARLY_DONE_EN when computing expected latencies.
module tb_alu_mult_seq;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic           sa;
      logic           sb;
      logic [2*W-1:0] prod;
      logic           sgn;
   } vec_t;

   typedef struct {
      logic [2*W-1:0] prod;
      logic           sgn;
      int             lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad = 0;
   exp_t sb_q[$];
   vec_t vecs[10];

   alu_mult_if #(.WIDTH(W)) bus ();

   alu_mult_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // Reference latency: full WIDTH iterations, or MSB position of b + 1 when
   // early termination is built in.
   function automatic int expLatency(input logic [W-1:0] b);
      int lat;
`ifdef ALU_MULT_EARLY_DONE_EN
      lat = 0;
      for (int i = 0; i < W; i++) begin
         if (b[i]) lat = i + 1;
      end
`else
      lat = W;
`endif
      return lat;
   endfunction

   // Waits for in_ready, presents one operand set for a single accept edge,
   // and pushes the expected result. Returns at the negedge after accept.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic sa, input logic sgb,
                                input logic [2*W-1:0] prod, input logic sgn);
      exp_t e;
      int   guard;
      guard = 0;
      @(negedge clk);
      while (!bus.in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkValue("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
      bus.a        = a;
      bus.b        = b;
      bus.sign_a   = sa;
      bus.sign_b   = sgb;
      bus.in_valid = 1'b1;
      e.prod = prod;
      e.sgn  = sgn;
      e.lat  = expLatency(b);
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // Counts edges after the accept edge until out_valid, checking that the
   // block reports busy and refuses input meanwhile.
   task automatic waitResult(output int lat);
      bit run_ok;
      run_ok = 1'b1;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         if (!bus.busy || bus.in_ready) run_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      checkValue("out_valid_timeout", 32'(bus.out_valid), 32'd1);
      checkValue("busy_during_run", 32'(run_ok), 32'd1);
   endtask

   // Pops the scoreboard, compares the held result, then completes the
   // handshake and confirms the return to IDLE.
   task automatic checkOutput(input string tag, input int lat);
      exp_t e;
      if (sb_q.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL %s_scoreboard actual=empty required=entry", tag);
         return;
      end
      e = sb_q.pop_front();
      checkValue({tag, "_product"}, 32'(bus.product), 32'(e.prod));
      checkValue({tag, "_sign"}, 32'(bus.final_sign), 32'(e.sgn));
      checkValue({tag, "_latency"}, lat, e.lat);
      checkValue({tag, "_done_status"}, {30'd0, bus.busy, bus.in_ready}, 32'b10);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      checkValue({tag, "_after_handshake"},
                 {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'b010);
   endtask

   initial begin
      int lat;

      vecs[0] = '{a: 8'd13,  b: 8'd11,  sa: 1'b0, sb: 1'b0, prod: 16'd143,   sgn: 1'b0};
      vecs[1] = '{a: 8'd255, b: 8'd255, sa: 1'b1, sb: 1'b0, prod: 16'd65025, sgn: 1'b1};
      vecs[2] = '{a: 8'd0,   b: 8'd77,  sa: 1'b1, sb: 1'b0, prod: 16'd0,     sgn: 1'b0};
      vecs[3] = '{a: 8'd100, b: 8'd0,   sa: 1'b0, sb: 1'b1, prod: 16'd0,     sgn: 1'b0};
      vecs[4] = '{a: 8'd6,   b: 8'd7,   sa: 1'b1, sb: 1'b1, prod: 16'd42,    sgn: 1'b0};
      vecs[5] = '{a: 8'd1,   b: 8'd255, sa: 1'b0, sb: 1'b1, prod: 16'd255,   sgn: 1'b1};
      vecs[6] = '{a: 8'd128, b: 8'd2,   sa: 1'b1, sb: 1'b1, prod: 16'd256,   sgn: 1'b0};
      vecs[7] = '{a: 8'd200, b: 8'd1,   sa: 1'b0, sb: 1'b0, prod: 16'd200,   sgn: 1'b0};
      vecs[8] = '{a: 8'd200, b: 8'd3,   sa: 1'b1, sb: 1'b0, prod: 16'd600,   sgn: 1'b1};
      vecs[9] = '{a: 8'd200, b: 8'h80,  sa: 1'b0, sb: 1'b0, prod: 16'd25600, sgn: 1'b0};

      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.sign_a    = 1'b0;
      bus.sign_b    = 1'b0;
      bus.out_ready = 1'b0;

      #1 rst_n = 1'b0;
      #2;
      checkValue("reset_outputs",
                 {13'd0, bus.in_ready, bus.out_valid, bus.busy, bus.final_sign, bus.product},
                 {13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, vecs[i].prod, vecs[i].sgn);
         waitResult(lat);
         checkOutput($sformatf("vec%0d", i), lat);
      end

      // Backpressure: result must hold for 20 cycles while stray inputs are ignored.
      applyStimulus(8'd13, 8'd11, 1'b1, 1'b1, 16'd143, 1'b0);
      waitResult(lat);
      bus.a = 8'd99;
      bus.b = 8'd99;
      for (int c = 0; c < 20; c++) begin
         bus.in_valid = c[0];
         @(negedge clk);
         checkValue($sformatf("bp_hold_%0d", c),
                    {13'd0, bus.out_valid, bus.in_ready, bus.final_sign, bus.product},
                    {13'd0, 1'b1, 1'b0, 1'b0, 16'd143});
      end
      bus.in_valid = 1'b1;
      checkOutput("backpressure", lat);
      bus.in_valid = 1'b0;
      checkValue("no_accept_on_handshake", 32'(sb_q.size()), 32'd0);

      // Reset three edges into RUN: outputs drop without waiting for a clock.
      applyStimulus(8'd50, 8'd50, 1'b1, 1'b0, 16'd2500, 1'b1);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkValue("midrun_reset",
                 {13'd0, bus.in_ready, bus.out_valid, bus.busy, bus.final_sign, bus.product},
                 {13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(8'd6, 8'd7, 1'b0, 1'b1, 16'd42, 1'b1);
      waitResult(lat);
      checkOutput("after_reset", lat);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
